// File: rtl/cmd_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frame_pkg
// Brief    : Shared types and constants for the framed command parser.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_CH   = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [7:0] OP_DUTY    = 8'h44;
    localparam logic [7:0] OP_FREQ    = 8'h46;
    localparam logic [7:0] OP_EN      = 8'h45;
    localparam logic [7:0] C_RESP_ACK = 8'h06;
    localparam logic [7:0] C_RESP_NAK = 8'h15;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_DUTY) || (b == OP_FREQ) || (b == OP_EN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cmd_timeout_cnt
// Brief    : Inter-byte idle counter; expire is high in the cycle the count
//            reaches TIMEOUT_CYC. TIMEOUT_CYC = 0 disables it.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_counter
            localparam int C_CW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [C_CW-1:0] C_LAST = C_CW'(TIMEOUT_CYC - 1);

            logic [C_CW-1:0] r_cnt;
            logic            w_hit;

            // A byte arriving in the same cycle always wins over expiry.
            assign w_hit  = en && !clr && (r_cnt == C_LAST);
            assign expire = w_hit;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (clr || !en || w_hit) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cmd_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frame_parser
// Brief    : Parses SOF/CMD/CH/payload/CSUM frames and maintains per-channel
//            PWM duty, divider and enable registers with ACK/NAK responses.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter int         DATA_W      = 16,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SOF_BYTE    = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [NUM_CH*DATA_W-1:0] duty_flat,
    output logic [NUM_CH*DATA_W-1:0] freq_div_flat,
    output logic [NUM_CH-1:0]        enable,
    output logic [NUM_CH-1:0]        cfg_valid,
    output logic                     resp_valid,
    output logic [7:0]               resp_data,
    input  logic                     resp_ready,
    output logic                     err_timeout
);

    localparam int C_NBYTES = DATA_W / 8;
    localparam int C_BCW    = (C_NBYTES > 1) ? $clog2(C_NBYTES) : 1;
    localparam logic [C_BCW-1:0] C_LAST_BYTE = C_BCW'(C_NBYTES - 1);

    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [7:0]          r_ch;
    logic [7:0]          r_csum;
    logic [DATA_W-1:0]   r_acc;
    logic [C_BCW-1:0]    r_bcnt;
    logic                r_bad;

    logic [DATA_W-1:0]   r_duty [NUM_CH];
    logic [DATA_W-1:0]   r_fdiv [NUM_CH];
    logic [NUM_CH-1:0]   r_enable;
    logic [NUM_CH-1:0]   r_cfg_valid;
    logic                r_resp_valid;
    logic [7:0]          r_resp_data;
    logic                r_err_timeout;

    logic                w_expire;
    logic                w_ch_ok;
    logic                w_frame_ok;

    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid),
        .en     (r_state != ST_IDLE),
        .expire (w_expire)
    );

    assign w_ch_ok    = int'(rx_data) < NUM_CH;
    // r_bad carries an early bad-CMD/CH verdict so the frame is still consumed.
    assign w_frame_ok = !r_bad && (rx_data == r_csum) &&
                        !((r_cmd == OP_FREQ) && (r_acc == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_ch          <= '0;
            r_csum        <= '0;
            r_acc         <= '0;
            r_bcnt        <= '0;
            r_bad         <= 1'b0;
            r_enable      <= '0;
            r_cfg_valid   <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_err_timeout <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
                r_fdiv[i] <= DATA_W'(1);
            end
        end else begin
            r_cfg_valid   <= '0;
            r_err_timeout <= 1'b0;
            if (r_resp_valid && resp_ready) begin
                r_resp_valid <= 1'b0;
            end

            if (w_expire) begin
                r_state       <= ST_IDLE;
                r_bcnt        <= '0;
                r_bad         <= 1'b0;
                r_acc         <= '0;
                r_err_timeout <= 1'b1;
            end else if (rx_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_data == SOF_BYTE) begin
                            r_state <= ST_CMD;
                            r_bad   <= 1'b0;
                            r_bcnt  <= '0;
                            r_acc   <= '0;
                        end
                    end
                    ST_CMD: begin
                        r_cmd   <= rx_data;
                        r_csum  <= rx_data;
                        r_bad   <= !is_opcode(rx_data);
                        r_state <= ST_CH;
                    end
                    ST_CH: begin
                        r_ch    <= rx_data;
                        r_csum  <= r_csum ^ rx_data;
                        r_bad   <= r_bad || !w_ch_ok;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_acc  <= (r_acc << 8) | DATA_W'(rx_data);
                        r_csum <= r_csum ^ rx_data;
                        if (r_bcnt == C_LAST_BYTE) begin
                            r_bcnt  <= '0;
                            r_state <= ST_CSUM;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    ST_CSUM: begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_frame_ok ? C_RESP_ACK : C_RESP_NAK;
                        if (w_frame_ok) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (r_ch == 8'(i)) begin
                                    r_cfg_valid[i] <= 1'b1;
                                    if (r_cmd == OP_DUTY) r_duty[i]   <= r_acc;
                                    if (r_cmd == OP_FREQ) r_fdiv[i]   <= r_acc;
                                    if (r_cmd == OP_EN)   r_enable[i] <= r_acc[0];
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
            assign duty_flat[g*DATA_W +: DATA_W]     = r_duty[g];
            assign freq_div_flat[g*DATA_W +: DATA_W] = r_fdiv[g];
        end
    endgenerate

    assign enable      = r_enable;
    assign cfg_valid   = r_cfg_valid;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_frame_parser
// Brief    : Directed and randomized frames against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_parser;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int TO  = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic [NCH*DW-1:0] duty_flat;
    logic [NCH*DW-1:0] freq_div_flat;
    logic [NCH-1:0]    enable;
    logic [NCH-1:0]    cfg_valid;
    logic              resp_valid;
    logic [7:0]        resp_data;
    logic              resp_ready = 1'b1;
    logic              err_timeout;

    cmd_frame_parser #(
        .NUM_CH      (NCH),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO),
        .SOF_BYTE    (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .duty_flat     (duty_flat),
        .freq_div_flat (freq_div_flat),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_ready    (resp_ready),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_duty [NCH];
    logic [15:0] m_fdiv [NCH];
    logic [3:0]  m_en;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_duty[i] = 16'h0000;
            m_fdiv[i] = 16'h0001;
        end
        m_en = '0;
    endtask

    task automatic check_regs(input string tag);
        logic [63:0] ed, ef;
        for (int i = 0; i < NCH; i++) begin
            ed[i*16 +: 16] = m_duty[i];
            ef[i*16 +: 16] = m_fdiv[i];
        end
        check_eq({tag, ".duty"}, duty_flat, ed);
        check_eq({tag, ".fdiv"}, freq_div_flat, ef);
        check_eq({tag, ".en"}, 64'(enable), 64'(m_en));
    endtask

    // Called at a negedge; returns at the negedge right after the consuming posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] cmd, input logic [7:0] ch,
                              input logic [15:0] pay, input logic [7:0] xmask, input int maxgap);
        logic [7:0] csum;
        logic       ok;
        logic [3:0] exp_cfg;
        csum = cmd ^ ch ^ pay[15:8] ^ pay[7:0] ^ xmask;
        ok   = (xmask == 8'h00) && (cmd == 8'h44 || cmd == 8'h45 || cmd == 8'h46) &&
               (ch < NCH) && !(cmd == 8'h46 && pay == 16'h0000);
        send_byte(8'hA5, $urandom_range(0, maxgap));
        send_byte(cmd, $urandom_range(0, maxgap));
        send_byte(ch, $urandom_range(0, maxgap));
        send_byte(pay[15:8], $urandom_range(0, maxgap));
        send_byte(pay[7:0], $urandom_range(0, maxgap));
        send_byte(csum, 0);
        exp_cfg = '0;
        if (ok) begin
            exp_cfg[ch[1:0]] = 1'b1;
            if (cmd == 8'h44) m_duty[ch[1:0]] = pay;
            if (cmd == 8'h46) m_fdiv[ch[1:0]] = pay;
            if (cmd == 8'h45) m_en[ch[1:0]]   = pay[0];
        end
        check_eq({tag, ".cfg"}, 64'(cfg_valid), 64'(exp_cfg));
        check_eq({tag, ".rv"}, 64'(resp_valid), 64'd1);
        check_eq({tag, ".rd"}, 64'(resp_data), ok ? 64'h06 : 64'h15);
        check_regs(tag);
        @(negedge clk);
        check_eq({tag, ".cfg_end"}, 64'(cfg_valid), 64'd0);
        if (resp_ready) check_eq({tag, ".rv_drop"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [7:0] cmd, noise;
        logic [15:0] pay;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("reset.cfg", 64'(cfg_valid), 64'd0);
        check_eq("reset.rv", 64'(resp_valid), 64'd0);
        check_eq("reset.rd", 64'(resp_data), 64'd0);
        check_eq("reset.to", 64'(err_timeout), 64'd0);
        check_regs("reset");

        send_frame("duty_ch2", 8'h44, 8'h02, 16'h1234, 8'h00, 0);
        send_frame("bad_csum", 8'h44, 8'h02, 16'h5678, 8'h01, 0);
        send_frame("freq_zero", 8'h46, 8'h01, 16'h0000, 8'h00, 0);
        send_frame("ch_range", 8'h46, 8'h05, 16'h0010, 8'h00, 0);
        send_frame("bad_cmd", 8'h47, 8'h00, 16'h0001, 8'h00, 1);
        send_frame("en_ch3", 8'h45, 8'h03, 16'h0001, 8'h00, 2);

        // Partial frame followed by silence must abort with a single pulse.
        send_byte(8'hA5, 0);
        send_byte(8'h44, 0);
        send_byte(8'h00, 0);
        pulses = 0;
        for (int c = 0; c < TO + 20; c++) begin
            @(negedge clk);
            if (err_timeout) pulses++;
            check_eq("timeout.rv", 64'(resp_valid), 64'd0);
        end
        check_eq("timeout.pulses", 64'(pulses), 64'd1);
        check_regs("timeout");
        send_frame("after_to", 8'h44, 8'h00, 16'hBEEF, 8'h00, 0);

        resp_ready = 1'b0;
        send_frame("hold1", 8'h46, 8'h01, 16'h0100, 8'h00, 0);
        repeat (3) @(negedge clk);
        check_eq("hold.rv", 64'(resp_valid), 64'd1);
        check_eq("hold.rd", 64'(resp_data), 64'h06);
        send_frame("hold2", 8'h46, 8'h01, 16'h0200, 8'h80, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("release.rv", 64'(resp_valid), 64'd0);

        send_frame("pre_rst", 8'h44, 8'h03, 16'hCAFE, 8'h00, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h44, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_mid.cfg", 64'(cfg_valid), 64'd0);
        check_eq("rst_mid.rv", 64'(resp_valid), 64'd0);
        check_eq("rst_mid.rd", 64'(resp_data), 64'd0);
        check_regs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame("post_rst", 8'h44, 8'h01, 16'h00AA, 8'h00, 0);

        for (int f = 0; f < 150; f++) begin
            repeat ($urandom_range(0, 2)) begin
                noise = 8'($urandom);
                if (noise == 8'hA5) noise = 8'h00;
                send_byte(noise, $urandom_range(0, 2));
            end
            case ($urandom_range(0, 9))
                0, 1, 2: cmd = 8'h44;
                3, 4, 5: cmd = 8'h46;
                6, 7:    cmd = 8'h45;
                default: cmd = 8'($urandom);
            endcase
            pay = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            send_frame($sformatf("rnd%0d", f), cmd, 8'($urandom_range(0, 5)), pay,
                       ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
